// File: rtl/quarter_wave_sequencer.sv
// Phase accumulator and quadrant mirroring front end for a quarter-cycle sine ROM.
// Ports: clk, rst_n (async, active low), enable, phase_step, rom_address, rom_data,
//        sample_out (10-bit unsigned), sample_valid, period_start.
module quarter_wave_sequencer #(
   parameter int PHASE_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [PHASE_WIDTH-1:0] phase_step,
   output logic [6:0]             rom_address,
   input  logic [8:0]             rom_data,
   output logic [9:0]             sample_out,
   output logic                   sample_valid,
   output logic                   period_start
);

   localparam int PW = PHASE_WIDTH;

   logic [PW-1:0] phase_q, phase_d;
   logic          wrap_d;
   // Marks that the current phase_q begins a new period.
   logic          first_q;

   logic          s1_valid_q;
   logic [1:0]    s1_quad_q;
   logic          s1_first_q;

   logic [9:0]    sample_q, sample_d;
   logic          valid_q;
   logic          start_q;

   logic [1:0]    quad;
   logic [6:0]    idx;

   assign quad = phase_q[PW-1:PW-2];
   assign idx  = phase_q[PW-3:PW-9];

   // Odd quadrants run the table backwards.
   assign rom_address = quad[0] ? 7'd127 - idx : idx;

   always_comb begin
      {wrap_d, phase_d} = {1'b0, phase_q} + {1'b0, phase_step};
   end

   // Upper half of the cycle is mirrored below mid-scale.
   always_comb begin
      if (s1_quad_q[1]) begin
         sample_d = 10'd511 - {1'b0, rom_data};
      end else begin
         sample_d = 10'd512 + {1'b0, rom_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= '0;
         first_q    <= 1'b1;
         s1_valid_q <= 1'b0;
         s1_quad_q  <= 2'd0;
         s1_first_q <= 1'b0;
         sample_q   <= 10'd512;
         valid_q    <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         if (enable) begin
            phase_q    <= phase_d;
            first_q    <= wrap_d;
            s1_valid_q <= 1'b1;
            s1_quad_q  <= quad;
            s1_first_q <= first_q;
         end else begin
            s1_valid_q <= 1'b0;
         end

         if (s1_valid_q) begin
            sample_q <= sample_d;
            valid_q  <= 1'b1;
            start_q  <= s1_first_q;
         end else begin
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
         end
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign period_start = start_q;

endmodule

// File: tb/tb_quarter_wave_sequencer.sv
// Scoreboard bench for quarter_wave_sequencer with a sine ROM model rom[i]=4*i.
// Ports exercised: all; expected samples come from a phase-level reference model.
module tb_quarter_wave_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] phase_step = '0;
   logic [6:0]  rom_address;
   logic [8:0]  rom_data;
   logic [9:0]  sample_out;
   logic        sample_valid;
   logic        period_start;

   quarter_wave_sequencer #(.PHASE_WIDTH(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .phase_step   (phase_step),
      .rom_address  (rom_address),
      .rom_data     (rom_data),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   logic [8:0] rom [128];
   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 9'(4 * i);
   end
   always_ff @(posedge clk) rom_data <= rom[rom_address];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int sample;
      int first;
      int phase;
   } exp_t;

   exp_t exp_q[$];

   int  m_phase;
   bit  m_first;
   bit  done = 0;

   function automatic int ref_addr(input int ph);
      int quad, idx;
      quad = ph / 16384;
      idx  = (ph % 16384) / 128;
      return (quad % 2 == 1) ? 127 - idx : idx;
   endfunction

   function automatic int ref_sample(input int ph);
      int v;
      v = 4 * ref_addr(ph);
      return (ph >= 32768) ? 511 - v : 512 + v;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_first = 1;
   endtask

   task automatic step_cycle(input bit en, input int step);
      exp_t e;
      @(negedge clk);
      check("rom_address", int'(rom_address), ref_addr(m_phase));
      enable     = en;
      phase_step = 16'(step);
      if (en) begin
         e.sample = ref_sample(m_phase);
         e.first  = int'(m_first);
         e.phase  = m_phase;
         exp_q.push_back(e);
         m_first = (m_phase + step) >= 65536;
         m_phase = (m_phase + step) % 65536;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      enable = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check("rst_sample_out", int'(sample_out), 512);
      check("rst_sample_valid", int'(sample_valid), 0);
      check("rst_period_start", int'(period_start), 0);
      check("rst_rom_address", int'(rom_address), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops one expectation per valid strobe, otherwise checks hold.
   int last_out = 512;
   int n_starts = 0;
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            last_out = 512;
         end else if (sample_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sample_out", int'(sample_out), e.sample);
               check("period_start", int'(period_start), e.first);
            end
            if (period_start) n_starts++;
            last_out = int'(sample_out);
         end else begin
            check("hold_sample_out", int'(sample_out), last_out);
            check("idle_period_start", int'(period_start), 0);
         end
      end
   end

   initial begin
      int s0;
      model_reset();
      do_reset();

      // Steady sweep through one full period and into the next.
      s0 = n_starts;
      for (int i = 0; i < 520; i++) step_cycle(1, 16'h0080);
      step_cycle(0, 0);
      step_cycle(0, 0);
      step_cycle(0, 0);
      check("sweep_period_starts", n_starts - s0, 2);

      // Enable gaps mid-run.
      for (int i = 0; i < 5; i++) step_cycle(1, 16'h0080);
      for (int i = 0; i < 3; i++) step_cycle(0, 16'h0080);
      for (int i = 0; i < 5; i++) step_cycle(1, 16'h0080);

      // Half-cycle step alternates mid-scale neighbours.
      do_reset();
      for (int i = 0; i < 12; i++) step_cycle(1, 16'h8000);

      // Zero step: constant output, one period start.
      do_reset();
      s0 = n_starts;
      for (int i = 0; i < 20; i++) step_cycle(1, 0);
      step_cycle(0, 0);
      step_cycle(0, 0);
      step_cycle(0, 0);
      check("zero_step_starts", n_starts - s0, 1);

      // Random steps and enables, with occasional mid-stream reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            int st;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 2047));
            step_cycle($urandom_range(0, 9) < 7, st);
         end
      end

      for (int i = 0; i < 4; i++) step_cycle(0, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      done = 1;
      @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
